// File: rtl/gtx_pkg.sv
// Shared constants and types for the GTX TX framer and the related RX alignment logic.
package gtx_pkg;

    localparam logic [7:0] K_COMMA = 8'hBC;
    localparam logic [7:0] K_IDLE  = 8'h1C;
    localparam logic [7:0] K_SOF   = 8'hFB;
    localparam logic [7:0] K_EOF   = 8'hFD;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        EOF
    } state_e;

    // Callers truncate the result to their own lane count (at most 8 lanes).
    function automatic logic [63:0] rep_byte(input logic [7:0] b);
        return {8{b}};
    endfunction

endpackage

// File: rtl/gtx_comma_timer.sv
// Free-running comma slot timer: comma_o is high for one word in every COMMA_PERIOD words.
module gtx_comma_timer #(
    parameter int unsigned COMMA_PERIOD = 256
) (
    input  logic clk_i,
    input  logic rst_n_i,
    output logic comma_o
);

    localparam int unsigned CNT_W = (COMMA_PERIOD > 1) ? $clog2(COMMA_PERIOD) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(COMMA_PERIOD - 1)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign comma_o = (cnt_q == '0);

endmodule

// File: rtl/gtx_tx_framer.sv
// GTX transmit framer: periodic comma, idle fill and SOF/payload/EOF framing of a
// valid/ready/last packet source onto TXDATA/TXCHARISK.
module gtx_tx_framer
    import gtx_pkg::*;
#(
    parameter int unsigned BYTES        = 2,
    parameter int unsigned COMMA_PERIOD = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [8*BYTES-1:0]   data_i,
    input  logic                 valid_i,
    input  logic                 last_i,
    output logic                 ready_o,
    output logic [BYTES-1:0]     ctrl_o,
    output logic [8*BYTES-1:0]   data_o,
    output logic [15:0]          frame_cnt_o
);

    localparam int unsigned DW = 8 * BYTES;

    localparam logic [DW-1:0] W_COMMA = DW'(rep_byte(K_COMMA));
    localparam logic [DW-1:0] W_IDLE  = DW'(rep_byte(K_IDLE));
    localparam logic [DW-1:0] W_SOF   = DW'(rep_byte(K_SOF));
    localparam logic [DW-1:0] W_EOF   = DW'(rep_byte(K_EOF));

    logic              comma;
    state_e            state_q, state_d;
    logic [BYTES-1:0]  ctrl_q, ctrl_d;
    logic [DW-1:0]     data_q, data_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;

    gtx_comma_timer #(
        .COMMA_PERIOD (COMMA_PERIOD)
    ) u_comma_timer (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .comma_o (comma)
    );

    // Comma slots freeze the FSM, so a pending EOF simply slips by one word.
    always_comb begin
        state_d     = state_q;
        ctrl_d      = '1;
        data_d      = W_IDLE;
        frame_cnt_d = frame_cnt_q;
        if (comma) begin
            data_d = W_COMMA;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        data_d  = W_SOF;
                        state_d = DATA;
                    end
                end
                DATA: begin
                    if (valid_i) begin
                        data_d = data_i;
                        ctrl_d = '0;
                        if (last_i) begin
                            state_d = EOF;
                        end
                    end
                end
                EOF: begin
                    data_d      = W_EOF;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            ctrl_q      <= '0;
            data_q      <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            data_q      <= data_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign ready_o     = rst_n_i && (state_q == DATA) && !comma;
    assign ctrl_o      = ctrl_q;
    assign data_o      = data_q;
    assign frame_cnt_o = frame_cnt_q;

endmodule
